// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchronised input, oversampled 3-point majority vote,
// optional parity, one or two stop bits, parity/framing flags and a one-cycle dout_valid strobe.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int WL         = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          din,
  output logic [WL-1:0] dout,
  output logic          dout_valid,
  output logic          parity_err,
  output logic          frame_err,
  output logic          busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(DIV) + 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(WL + 1);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(M - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(M);
  localparam logic [SW-1:0] SAMP_C    = SW'(M + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WL);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);
  localparam bit            HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          din_meta_reg;
  logic          din_s_reg;
  logic          din_d_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] sample_cnt_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [2:0]    state_reg;
  logic [WL-1:0] shift_reg;
  logic          vote_a_reg;
  logic          vote_b_reg;
  logic          perr_reg;
  logic          ferr_reg;
  logic [WL-1:0] dout_reg;
  logic          dout_valid_reg;
  logic          parity_err_reg;
  logic          frame_err_reg;
  logic          busy_reg;

  logic tick;
  logic start_edge;
  logic in_frame;
  logic decide;
  logic bit_end;
  logic voted_bit;

  assign tick       = (tick_cnt_reg == TICK_LAST);
  assign start_edge = din_d_reg & ~din_s_reg;
  assign in_frame   = (state_reg != S_IDLE);
  assign decide     = tick && (sample_cnt_reg == SAMP_C);
  assign bit_end    = tick && (sample_cnt_reg == SAMP_LAST);
  // Third vote sample is the live synchronised input at index M+1.
  assign voted_bit  = (vote_a_reg & vote_b_reg) | (vote_a_reg & din_s_reg) |
                      (vote_b_reg & din_s_reg);

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = busy_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      din_meta_reg   <= 1'b1;
      din_s_reg      <= 1'b1;
      din_d_reg      <= 1'b1;
      tick_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      vote_a_reg     <= 1'b0;
      vote_b_reg     <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      din_meta_reg   <= din;
      din_s_reg      <= din_meta_reg;
      din_d_reg      <= din_s_reg;
      dout_valid_reg <= 1'b0;

      // Tick phase is re-aligned to the falling edge of every start bit.
      if (!in_frame && start_edge) begin
        tick_cnt_reg <= '0;
      end else if (tick) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + TW'(1);
      end

      if (!in_frame) begin
        sample_cnt_reg <= '0;
      end else if (tick) begin
        sample_cnt_reg <= (sample_cnt_reg == SAMP_LAST) ? '0 : sample_cnt_reg + SW'(1);
      end

      if (in_frame && tick && (sample_cnt_reg == SAMP_A)) begin
        vote_a_reg <= din_s_reg;
      end
      if (in_frame && tick && (sample_cnt_reg == SAMP_B)) begin
        vote_b_reg <= din_s_reg;
      end

      case (state_reg)
        S_IDLE: begin
          if (start_edge) begin
            state_reg   <= S_START;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
          end
        end
        S_START: begin
          if (decide && voted_bit) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else if (bit_end) begin
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (decide) begin
            shift_reg   <= {voted_bit, shift_reg[WL-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
          if (bit_end && (bit_cnt_reg == DATA_LAST)) begin
            bit_cnt_reg <= '0;
            state_reg   <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (decide) begin
            perr_reg <= (^shift_reg) ^ voted_bit ^ PAR_ODD;
          end
          if (bit_end) begin
            state_reg <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop lets the next start bit follow with no idle time.
          if (decide) begin
            if (bit_cnt_reg == STOP_LAST) begin
              dout_reg       <= shift_reg;
              parity_err_reg <= perr_reg;
              frame_err_reg  <= ferr_reg | ~voted_bit;
              dout_valid_reg <= 1'b1;
              busy_reg       <= 1'b0;
              state_reg      <= S_IDLE;
            end else begin
              ferr_reg    <= ferr_reg | ~voted_bit;
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receivers (8N1, 8E1, 8O1, 8N2) share one serial line;
// expected frames go into a queue and are matched against strobes captured per receiver.
module tb_uart_rx_param;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 16;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            din = 1'b1;
  logic [3:0][7:0] dout_w;
  logic [3:0]      dv;
  logic [3:0]      pe;
  logic [3:0]      fe;
  logic [3:0]      bz;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 CLK = ~CLK;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                  .WL(8), .PARITY(0), .STOP_BITS(1)) dut_n1 (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dout(dout_w[0]), .dout_valid(dv[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                  .WL(8), .PARITY(1), .STOP_BITS(1)) dut_e1 (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dout(dout_w[1]), .dout_valid(dv[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                  .WL(8), .PARITY(2), .STOP_BITS(1)) dut_o1 (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dout(dout_w[2]), .dout_valid(dv[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
                  .WL(8), .PARITY(0), .STOP_BITS(2)) dut_n2 (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dout(dout_w[3]), .dout_valid(dv[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .busy(bz[3]));

  // One entry per cycle dout_valid is high, so a wide strobe shows up as an extra event.
  always @(negedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1) begin
        ev_t ev;
        ev.id   = 2'(k);
        ev.data = dout_w[k];
        ev.pe   = pe[k];
        ev.fe   = fe[k];
        obs_q.push_back(ev);
        $display("strobe dut%0d: dout=%h parity_err=%b frame_err=%b", k, ev.data, ev.pe, ev.fe);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, want finish");
    $fatal(1);
  end

  function automatic ev_t mk(input int id, input logic [7:0] d, input logic p, input logic f);
    ev_t e;
    e.id = 2'(id);
    e.data = d;
    e.pe = p;
    e.fe = f;
    return e;
  endfunction

  function automatic int count_id(input int k);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i].id == 2'(k)) c++;
    return c;
  endfunction

  function automatic ev_t pop_id(input int k);
    ev_t r = '0;
    int  idx = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (idx < 0 && obs_q[i].id == 2'(k)) idx = i;
    end
    if (idx >= 0) begin
      r = obs_q[idx];
      obs_q.delete(idx);
    end
    return r;
  endfunction

  // Tasks enter and leave 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int glitch_c);
    for (int c = 0; c < BIT_CLKS; c++) begin
      din = (c == glitch_c) ? ~b : b;
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1, -1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic pbit,
                            input logic s1, input bit two_stop, input logic s2,
                            input int glitch_bit);
    drive_bit(1'b0, (glitch_bit == 0) ? 9 : -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (glitch_bit == i + 1) ? 9 : -1);
    if (par_en) drive_bit(pbit, -1);
    drive_bit(s1, -1);
    if (two_stop) drive_bit(s2, -1);
  endtask

  task automatic flush();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    din = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({dout_w[k], dv[k], pe[k], fe[k], bz[k]} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_dut%0d: got %h want 000", k, {dout_w[k], dv[k], pe[k], fe[k], bz[k]});
      end
    end
    RST_N = 1'b1;
    idle_bits(2);
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    idle_bits(4);
    flush();
    exp_q.push_back(mk(0, 8'hA5, 1'b0, 1'b0));
    send_frame(8'hA5, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    exp_q.push_back(mk(0, 8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle_bits(3);
    n_cmp++;
    if (count_id(0) !== 2) begin
      n_err++;
      $display("FAIL b2b_strobes: got %0d strobe cycles want 2", count_id(0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if (o.data !== e.data) begin
        n_err++;
        $display("FAIL b2b_data: got %h want %h", o.data, e.data);
      end
      n_cmp++;
      if ({o.pe, o.fe} !== {e.pe, e.fe}) begin
        n_err++;
        $display("FAIL b2b_flags: got pe=%b fe=%b want pe=%b fe=%b", o.pe, o.fe, e.pe, e.fe);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_midframe_reset();
    ev_t e, o;
    idle_bits(4);
    flush();
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, -1);
    din = 1'b1;
    repeat (6) begin @(posedge CLK); #1; end
    n_cmp++;
    if (bz[0] !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_frame: got %b want 1", bz[0]);
    end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({dout_w[k], dv[k], pe[k], fe[k], bz[k]} !== 12'h000) begin
        n_err++;
        $display("FAIL midreset_dut%0d: got %h want 000", k,
                 {dout_w[k], dv[k], pe[k], fe[k], bz[k]});
      end
    end
    RST_N = 1'b1;
    repeat (9) begin @(posedge CLK); #1; end
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    idle_bits(2);
    n_cmp++;
    if (count_id(0) !== 0) begin
      n_err++;
      $display("FAIL aborted_strobe: got %0d strobes want 0", count_id(0));
    end
    exp_q.push_back(mk(0, 8'h5A, 1'b0, 1'b0));
    send_frame(8'h5A, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle_bits(3);
    n_cmp++;
    if (count_id(0) !== 1) begin
      n_err++;
      $display("FAIL post_reset_strobes: got %0d want 1", count_id(0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if ({o.data, o.pe, o.fe} !== {e.data, e.pe, e.fe}) begin
        n_err++;
        $display("FAIL post_reset_frame: got %h/%b%b want %h/%b%b",
                 o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
    end
    $display("test_midframe_reset done");
  endtask

  task automatic test_parity();
    ev_t e, o;
    idle_bits(4);
    flush();
    exp_q.push_back(mk(1, 8'h03, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 8'h03, 1'b1, 1'b0));
    send_frame(8'h03, 1, 1'b0, 1'b1, 0, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(mk(1, 8'h03, 1'b1, 1'b0));
    exp_q.push_back(mk(2, 8'h03, 1'b0, 1'b0));
    send_frame(8'h03, 1, 1'b1, 1'b1, 0, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(mk(2, 8'h81, 1'b1, 1'b0));
    exp_q.push_back(mk(1, 8'h81, 1'b0, 1'b0));
    send_frame(8'h81, 1, 1'b0, 1'b1, 0, 1'b1, -1);
    idle_bits(3);
    for (int k = 1; k <= 2; k++) begin
      n_cmp++;
      if (count_id(k) !== 3) begin
        n_err++;
        $display("FAIL parity_strobes_dut%0d: got %0d want 3", k, count_id(k));
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if (o.data !== e.data) begin
        n_err++;
        $display("FAIL parity_data_dut%0d: got %h want %h", e.id, o.data, e.data);
      end
      n_cmp++;
      if ({o.pe, o.fe} !== {e.pe, e.fe}) begin
        n_err++;
        $display("FAIL parity_flags_dut%0d: got pe=%b fe=%b want pe=%b fe=%b",
                 e.id, o.pe, o.fe, e.pe, e.fe);
      end
    end
    $display("test_parity done");
  endtask

  task automatic test_framing();
    ev_t e, o;
    idle_bits(4);
    flush();
    exp_q.push_back(mk(0, 8'h55, 1'b0, 1'b1));
    send_frame(8'h55, 0, 1'b0, 1'b0, 0, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b1));
    din = 1'b0;
    repeat (30 * BIT_CLKS) begin @(posedge CLK); #1; end
    idle_bits(2);
    n_cmp++;
    if (count_id(0) !== 2) begin
      n_err++;
      $display("FAIL break_once: got %0d strobes want 2", count_id(0));
    end
    exp_q.push_back(mk(0, 8'h81, 1'b0, 1'b0));
    send_frame(8'h81, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle_bits(3);
    n_cmp++;
    if (count_id(0) !== 3) begin
      n_err++;
      $display("FAIL after_break_strobes: got %0d want 3", count_id(0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if ({o.data, o.pe, o.fe} !== {e.data, e.pe, e.fe}) begin
        n_err++;
        $display("FAIL framing_frame: got %h/%b%b want %h/%b%b",
                 o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
    end
    $display("test_framing done");
  endtask

  task automatic test_false_start();
    logic saw_busy;
    idle_bits(4);
    flush();
    din = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    din = 1'b1;
    saw_busy = 1'b0;
    repeat (BIT_CLKS) begin
      if (bz[0] === 1'b1) saw_busy = 1'b1;
      @(posedge CLK); #1;
    end
    n_cmp++;
    if (saw_busy !== 1'b1) begin
      n_err++;
      $display("FAIL false_start_busy_rise: got %b want 1", saw_busy);
    end
    n_cmp++;
    if (bz[0] !== 1'b0) begin
      n_err++;
      $display("FAIL false_start_busy_fall: got %b want 0", bz[0]);
    end
    idle_bits(2);
    n_cmp++;
    if (count_id(0) !== 0) begin
      n_err++;
      $display("FAIL false_start_strobe: got %0d want 0", count_id(0));
    end
    $display("test_false_start done");
  endtask

  task automatic test_glitch();
    ev_t e, o;
    idle_bits(4);
    flush();
    exp_q.push_back(mk(0, 8'h00, 1'b0, 1'b0));
    send_frame(8'h00, 0, 1'b0, 1'b1, 0, 1'b1, 4);
    idle_bits(3);
    n_cmp++;
    if (count_id(0) !== 1) begin
      n_err++;
      $display("FAIL glitch_strobes: got %0d want 1", count_id(0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if ({o.data, o.pe, o.fe} !== {e.data, e.pe, e.fe}) begin
        n_err++;
        $display("FAIL glitch_frame: got %h/%b%b want %h/%b%b",
                 o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_two_stop();
    ev_t e, o;
    idle_bits(4);
    flush();
    exp_q.push_back(mk(3, 8'h5A, 1'b0, 1'b1));
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1, 1'b0, -1);
    idle_bits(3);
    exp_q.push_back(mk(3, 8'hC3, 1'b0, 1'b0));
    send_frame(8'hC3, 0, 1'b0, 1'b1, 1, 1'b1, -1);
    idle_bits(3);
    n_cmp++;
    if (count_id(3) !== 2) begin
      n_err++;
      $display("FAIL two_stop_strobes: got %0d want 2", count_id(3));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pop_id(int'(e.id));
      n_cmp++;
      if ({o.data, o.pe, o.fe} !== {e.data, e.pe, e.fe}) begin
        n_err++;
        $display("FAIL two_stop_frame: got %h/%b%b want %h/%b%b",
                 o.data, o.pe, o.fe, e.data, e.pe, e.fe);
      end
    end
    $display("test_two_stop done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_midframe_reset();
    test_parity();
    test_framing();
    test_false_start();
    test_glitch();
    test_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
